// File: rtl/regfile_pkg.sv
// Shared defaults and register-count derivation for the scoreboarded register file.
package regfile_pkg;

   localparam int DEF_DATA_W   = 8;
   localparam int DEF_ADDR_W   = 3;
   localparam bit DEF_ZERO_REG = 1'b0;
   localparam bit DEF_BYPASS   = 1'b1;

   function automatic int nregs(input int addr_w);
      return 1 << addr_w;
   endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-destination tracker: per-register busy bits, reservation handshake, pending count.
module rf_scoreboard
   import regfile_pkg::*;
#(
   parameter  int ADDR_W   = DEF_ADDR_W,
   parameter  bit ZERO_REG = DEF_ZERO_REG,
   localparam int NREGS    = nregs(ADDR_W)
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              WRITE,
   input  logic [ADDR_W-1:0] INADDRESS,
   input  logic              RESV,
   input  logic [ADDR_W-1:0] RESVADDRESS,
   output logic              RESV_ACK,
   output logic [NREGS-1:0]  BUSY_VEC,
   output logic [ADDR_W:0]   PEND_CNT
);

   logic [NREGS-1:0] busy, busy_nxt;
   logic [ADDR_W:0]  cnt, cnt_nxt;

   // A write landing on the same register frees it in time for the new reservation.
   assign RESV_ACK = RESV && (!busy[RESVADDRESS] ||
                              (WRITE && (INADDRESS == RESVADDRESS)));

   always_comb begin
      busy_nxt = busy;
      if (WRITE)    busy_nxt[INADDRESS]   = 1'b0;
      if (RESV_ACK) busy_nxt[RESVADDRESS] = 1'b1;
      if (ZERO_REG) busy_nxt[0]           = 1'b0;
      cnt_nxt = '0;
      for (int i = 0; i < NREGS; i++)
         cnt_nxt = cnt_nxt + (ADDR_W+1)'(busy_nxt[i]);
   end

   // Count is registered from the same next-state vector, so it can never drift.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         busy <= '0;
         cnt  <= '0;
      end else begin
         busy <= busy_nxt;
         cnt  <= cnt_nxt;
      end
   end

   assign BUSY_VEC = busy;
   assign PEND_CNT = cnt;

endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with two combinational read ports, write bypass and a destination scoreboard.
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter  int DATA_W   = DEF_DATA_W,
   parameter  int ADDR_W   = DEF_ADDR_W,
   parameter  bit ZERO_REG = DEF_ZERO_REG,
   parameter  bit BYPASS   = DEF_BYPASS,
   localparam int NREGS    = nregs(ADDR_W)
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic [DATA_W-1:0] IN,
   input  logic [ADDR_W-1:0] INADDRESS,
   input  logic              WRITE,
   input  logic [ADDR_W-1:0] OUT1ADDRESS,
   input  logic [ADDR_W-1:0] OUT2ADDRESS,
   output logic [DATA_W-1:0] OUT1,
   output logic [DATA_W-1:0] OUT2,
   output logic              OUT1_VALID,
   output logic              OUT2_VALID,
   input  logic              RESV,
   input  logic [ADDR_W-1:0] RESVADDRESS,
   output logic              RESV_ACK,
   output logic [NREGS-1:0]  BUSY_VEC,
   output logic [ADDR_W:0]   PEND_CNT
);

   logic [NREGS-1:0][DATA_W-1:0] regs;
   logic [1:0][ADDR_W-1:0]       rd_addr;
   logic [1:0][DATA_W-1:0]       rd_data;
   logic [1:0]                   rd_vld;

   always_ff @(posedge CLK) begin
      if (RESET)
         regs <= '0;
      else if (WRITE && !(ZERO_REG && (INADDRESS == '0)))
         regs[INADDRESS] <= IN;
   end

   assign rd_addr = {OUT2ADDRESS, OUT1ADDRESS};

   for (genvar p = 0; p < 2; p++) begin : g_rd
      logic              byp, zero;
      logic [DATA_W-1:0] d;

      assign byp  = BYPASS && WRITE && (INADDRESS == rd_addr[p]);
      assign zero = ZERO_REG && (rd_addr[p] == '0);

      // Hard-wired zero wins over the bypass path.
      always_comb begin
         d = regs[rd_addr[p]];
         if (byp)  d = IN;
         if (zero) d = '0;
      end

      assign rd_data[p] = d;
      assign rd_vld[p]  = !BUSY_VEC[rd_addr[p]] || byp;
   end

   assign OUT1       = rd_data[0];
   assign OUT2       = rd_data[1];
   assign OUT1_VALID = rd_vld[0];
   assign OUT2_VALID = rd_vld[1];

   rf_scoreboard #(
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG)
   ) u_sb (
      .CLK         (CLK),
      .RESET       (RESET),
      .WRITE       (WRITE),
      .INADDRESS   (INADDRESS),
      .RESV        (RESV),
      .RESVADDRESS (RESVADDRESS),
      .RESV_ACK    (RESV_ACK),
      .BUSY_VEC    (BUSY_VEC),
      .PEND_CNT    (PEND_CNT)
   );

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench: default instance plus a ZERO_REG=1 instance driven by the same stimulus.
module tb_regfile_scoreboard;

   logic       CLK = 1'b0;
   logic       RESET, WRITE, RESV;
   logic [7:0] IN;
   logic [2:0] INADDRESS, OUT1ADDRESS, OUT2ADDRESS, RESVADDRESS;

   logic [7:0] out1, out2, z_out1, z_out2;
   logic       v1, v2, ack, z_v1, z_v2, z_ack;
   logic [7:0] busy, z_busy;
   logic [3:0] pend, z_pend;

   int n_chk = 0;
   int n_err = 0;

   always #5 CLK = ~CLK;

   regfile_scoreboard dut (
      .CLK(CLK), .RESET(RESET), .IN(IN), .INADDRESS(INADDRESS), .WRITE(WRITE),
      .OUT1ADDRESS(OUT1ADDRESS), .OUT2ADDRESS(OUT2ADDRESS),
      .OUT1(out1), .OUT2(out2), .OUT1_VALID(v1), .OUT2_VALID(v2),
      .RESV(RESV), .RESVADDRESS(RESVADDRESS), .RESV_ACK(ack),
      .BUSY_VEC(busy), .PEND_CNT(pend)
   );

   regfile_scoreboard #(.ZERO_REG(1'b1)) dutz (
      .CLK(CLK), .RESET(RESET), .IN(IN), .INADDRESS(INADDRESS), .WRITE(WRITE),
      .OUT1ADDRESS(OUT1ADDRESS), .OUT2ADDRESS(OUT2ADDRESS),
      .OUT1(z_out1), .OUT2(z_out2), .OUT1_VALID(z_v1), .OUT2_VALID(z_v2),
      .RESV(RESV), .RESVADDRESS(RESVADDRESS), .RESV_ACK(z_ack),
      .BUSY_VEC(z_busy), .PEND_CNT(z_pend)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance past the next rising edge; outputs are sampled 1ns later.
   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   initial begin
      RESET = 1'b1; WRITE = 1'b0; RESV = 1'b0; IN = '0;
      INADDRESS = '0; OUT1ADDRESS = '0; OUT2ADDRESS = '0; RESVADDRESS = '0;
      step();
      RESET = 1'b0;
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_pend", pend, 0);
      chk("rst_out1", out1, 0);
      chk("rst_v1", v1, 1);
      chk("rst_zbusy", z_busy, 0);

      // write r3, read back
      WRITE = 1'b1; INADDRESS = 3'd3; IN = 8'h5A;
      step();
      WRITE = 1'b0; OUT1ADDRESS = 3'd3;
      #1;
      chk("wr_r3", out1, 8'h5A);
      chk("wr_r3_v", v1, 1);

      // same-cycle bypass on port 2
      WRITE = 1'b1; INADDRESS = 3'd5; IN = 8'hC3; OUT2ADDRESS = 3'd5;
      #1;
      chk("byp_out2", out2, 8'hC3);
      chk("byp_v2", v2, 1);
      chk("byp_out1_r3", out1, 8'h5A);
      step();
      WRITE = 1'b0;
      #1;
      chk("commit_r5", out2, 8'hC3);
      chk("only_r5", out1, 8'h5A);

      // reserve r2, duplicate reserve rejected, write frees it
      RESV = 1'b1; RESVADDRESS = 3'd2;
      #1;
      chk("resv2_ack", ack, 1);
      step();
      OUT1ADDRESS = 3'd2;
      #1;
      chk("resv2_busy", busy, 8'h04);
      chk("resv2_pend", pend, 1);
      chk("resv2_v1", v1, 0);
      chk("resv2_dup_ack", ack, 0);
      step();
      chk("resv2_dup_busy", busy, 8'h04);
      chk("resv2_dup_pend", pend, 1);
      RESV = 1'b0; WRITE = 1'b1; INADDRESS = 3'd2; IN = 8'h11;
      #1;
      chk("wr2_byp", out1, 8'h11);
      chk("wr2_byp_v", v1, 1);
      step();
      WRITE = 1'b0;
      #1;
      chk("wr2_busy", busy, 0);
      chk("wr2_pend", pend, 0);
      chk("wr2_data", out1, 8'h11);

      // write + reserve same busy register
      RESV = 1'b1; RESVADDRESS = 3'd4;
      step();
      chk("resv4_busy", busy, 8'h10);
      WRITE = 1'b1; INADDRESS = 3'd4; IN = 8'h77;
      #1;
      chk("wr_resv4_ack", ack, 1);
      step();
      WRITE = 1'b0; RESV = 1'b0; OUT1ADDRESS = 3'd4;
      #1;
      chk("wr_resv4_busy", busy, 8'h10);
      chk("wr_resv4_pend", pend, 1);
      chk("wr_resv4_data", out1, 8'h77);
      chk("wr_resv4_v", v1, 0);

      // r0: ZERO_REG instance hard-wires it, default instance does not
      WRITE = 1'b1; INADDRESS = 3'd0; IN = 8'hFF;
      RESV = 1'b1; RESVADDRESS = 3'd0; OUT1ADDRESS = 3'd0;
      #1;
      chk("z_r0_byp", z_out1, 0);
      chk("z_r0_ack", z_ack, 1);
      chk("r0_byp", out1, 8'hFF);
      chk("r0_ack", ack, 1);
      step();
      WRITE = 1'b0; RESV = 1'b0;
      #1;
      chk("z_r0_data", z_out1, 0);
      chk("z_busy_r0", z_busy, 8'h10);
      chk("z_pend_r0", z_pend, 1);
      chk("r0_data", out1, 8'hFF);
      chk("r0_busy", busy, 8'h11);
      chk("r0_pend", pend, 2);

      // reserve everything, then reset with a write pending
      RESV = 1'b1;
      for (int i = 0; i < 8; i++) begin
         RESVADDRESS = 3'(i);
         step();
      end
      RESV = 1'b0;
      #1;
      chk("all_busy", busy, 8'hFF);
      chk("all_pend", pend, 8);
      chk("z_all_busy", z_busy, 8'hFE);
      chk("z_all_pend", z_pend, 7);
      RESET = 1'b1; WRITE = 1'b1; INADDRESS = 3'd1; IN = 8'hAB; OUT1ADDRESS = 3'd3;
      #1;
      chk("prerst_out1", out1, 8'h5A);
      step();
      RESET = 1'b0; WRITE = 1'b0;
      #1;
      chk("postrst_pend", pend, 0);
      chk("postrst_busy", busy, 0);
      chk("z_postrst_pend", z_pend, 0);
      for (int i = 0; i < 8; i++) begin
         OUT1ADDRESS = 3'(i);
         #1;
         chk($sformatf("postrst_r%0d", i), out1, 0);
         chk($sformatf("postrst_v%0d", i), v1, 1);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/regfile_scoreboard.md
REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 Parameter DATA_W, default 8, register width in bits.
REQ-002 Parameter ADDR_W, default 3, address width; NREGS = 2**ADDR_W registers.
REQ-003 Parameter ZERO_REG, default 0; when 1, register 0 reads as zero, ignores writes and is never busy.
REQ-004 Parameter BYPASS, default 1; when 1, a same-cycle write is forwarded to the read ports.
REQ-005 The block SHALL use one clock and a synchronous, active-high reset.
REQ-006 CLK  in  1  clock; all state changes on the rising edge.
REQ-007 RESET  in  1  synchronous active-high reset.
REQ-008 IN  in  DATA_W  write data.
REQ-009 INADDRESS  in  ADDR_W  write address.
REQ-010 WRITE  in  1  write enable.
REQ-011 OUT1ADDRESS, OUT2ADDRESS  in  ADDR_W  read addresses.
REQ-012 OUT1, OUT2  out  DATA_W  read data.
REQ-013 OUT1_VALID, OUT2_VALID  out  1  read data is current (register not pending).
REQ-014 RESV  in  1  request to reserve a destination register.
REQ-015 RESVADDRESS  in  ADDR_W  register to reserve.
REQ-016 RESV_ACK  out  1  reservation accepted this cycle.
REQ-017 BUSY_VEC  out  NREGS  per-register pending flag.
REQ-018 PEND_CNT  out  ADDR_W+1  number of set BUSY_VEC bits.

Function
REQ-019 Reads SHALL be combinational with zero delay: OUTn = reg[OUTnADDRESS].
REQ-020 With BYPASS=1, WRITE=1 and INADDRESS==OUTnADDRESS, OUTn SHALL equal IN in the same cycle.
REQ-021 Writes SHALL commit at the rising edge when WRITE=1; exactly one register changes.
REQ-022 With ZERO_REG=1, OUTn SHALL be 0 for address 0, regardless of bypass, and writes to 0 SHALL be discarded.
REQ-023 OUTn_VALID SHALL be !BUSY_VEC[OUTnADDRESS], or 1 when the bypass of REQ-020 is active.
REQ-024 RESV_ACK SHALL be RESV && (!BUSY_VEC[RESVADDRESS] || (WRITE && INADDRESS==RESVADDRESS)); the value is combinational.
REQ-025 An acknowledged reservation SHALL set BUSY_VEC[RESVADDRESS] at the edge; an unacknowledged one SHALL change nothing.
REQ-026 A write SHALL clear BUSY_VEC[INADDRESS] at the edge; writing a non-busy register is legal.
REQ-027 On a simultaneous write and acknowledged reserve to the same address, the data SHALL commit and the busy bit SHALL end at 1.
REQ-028 With ZERO_REG=1, a reservation of register 0 SHALL be acknowledged and leave BUSY_VEC[0]=0.
REQ-029 PEND_CNT SHALL track BUSY_VEC registered, never wrapping; its range is 0..NREGS.
REQ-030 BUSY_VEC and PEND_CNT SHALL be consistent every cycle (PEND_CNT == popcount(BUSY_VEC)).

Reset
REQ-031 At the edge with RESET=1, all registers SHALL become 0, BUSY_VEC=0 and PEND_CNT=0.
REQ-032 RESET SHALL override WRITE and RESV in the same cycle; neither takes effect.
REQ-033 During RESET the combinational outputs SHALL still follow REQ-019..REQ-024 on the pre-reset state.

Structure
REQ-034 Default parameter values and the NREGS derivation SHALL be placed in the shared package regfile_pkg.
REQ-035 Busy tracking, RESV_ACK and PEND_CNT SHALL be in the sub-module rf_scoreboard.
REQ-036 The storage and bypass logic SHALL be in the top level; the design SHALL contain no # delays.

Verification
REQ-037 RESET, then write 0x5A to r3, then read r3 on OUT1 -> OUT1=0x5A, OUT1_VALID=1.
REQ-038 WRITE=1, INADDRESS=5, IN=0xC3, OUT2ADDRESS=5 in the same cycle -> OUT2=0xC3 before the edge (BYPASS=1).
REQ-039 RESV r2 -> ack, BUSY_VEC[2]=1, PEND_CNT=1, OUT1_VALID=0 on r2; a second RESV r2 -> RESV_ACK=0; a write of 0x11 to r2 -> busy cleared, PEND_CNT=0.
REQ-040 Same cycle: WRITE r4=0x77 and RESV r4 while r4 is busy -> ack, r4=0x77, BUSY_VEC[4]=1, PEND_CNT unchanged.
REQ-041 ZERO_REG=1: write 0xFF to r0 and RESV r0 -> OUT1=0 on r0, RESV_ACK=1, BUSY_VEC[0]=0.
REQ-042 Reserve all 8 registers, then RESET with WRITE=1 -> PEND_CNT goes 8 then 0, all registers read 0x00.
